// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared state encodings, CA layout and pin-control decode for the HyperBus controller
package hyperbus_pkg;

    // One-hot controller states
    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_CMD     = 6'b000010,
        ST_LAT     = 6'b000100,
        ST_WRITE   = 6'b001000,
        ST_READ    = 6'b010000,
        ST_RECOVER = 6'b100000
    } state_t;

    // Command/address word layout
    localparam int CA_W         = 48;
    localparam int CA_RW_BIT    = 47;
    localparam int CA_AS_BIT    = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_ROW_HI    = 44;
    localparam int CA_ROW_LO    = 16;
    localparam int CA_COL_HI    = 2;
    localparam int CA_COL_LO    = 0;

    // Chip-select high time between transactions
    localparam int RECOVER_CLKS = 2;

    // Pin and handshake controls that depend only on the state
    typedef struct packed {
        logic       cs_n;
        logic       ck_en;
        logic       dq_oe;
        logic       rwds_oe;
        logic [1:0] rwds_o;
        logic       ready;
        logic       busy;
    } pin_ctl_t;

    localparam pin_ctl_t CTL_IDLE = '{cs_n: 1'b1, ck_en: 1'b0, dq_oe: 1'b0, rwds_oe: 1'b0,
                                      rwds_o: 2'b11, ready: 1'b0, busy: 1'b0};

    // Control values to register alongside a transition into state s
    function automatic pin_ctl_t ctl_for(state_t s);
        pin_ctl_t c;
        c = CTL_IDLE;
        case (s)
            ST_CMD: begin
                c.cs_n  = 1'b0;
                c.ck_en = 1'b1;
                c.dq_oe = 1'b1;
                c.busy  = 1'b1;
            end
            ST_LAT, ST_READ: begin
                c.cs_n  = 1'b0;
                c.ck_en = 1'b1;
                c.busy  = 1'b1;
            end
            ST_WRITE: begin
                c.cs_n    = 1'b0;
                c.ck_en   = 1'b1;
                c.dq_oe   = 1'b1;
                c.rwds_oe = 1'b1;
                c.rwds_o  = 2'b00;
                c.ready   = 1'b1;
                c.busy    = 1'b1;
            end
            ST_RECOVER: c.busy = 1'b1;
            default: c = CTL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hyperbus_ca_gen.sv
// rtl/hyperbus_ca_gen.sv - combinational 48-bit command/address word builder
module hyperbus_ca_gen
    import hyperbus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic                  rd,
    output logic [CA_W-1:0]       ca
);

    logic [31:0] adr32;

    assign adr32 = 32'(adr);

    // Memory space, linear burst; row/column split of the halfword address
    always_comb begin
        ca                      = '0;
        ca[CA_RW_BIT]           = rd;
        ca[CA_AS_BIT]           = 1'b0;
        ca[CA_BURST_BIT]        = 1'b1;
        ca[CA_ROW_HI:CA_ROW_LO] = adr32[31:3];
        ca[CA_COL_HI:CA_COL_LO] = adr32[2:0];
    end

endmodule

// File: rtl/hyperbus_ctrl.sv
// rtl/hyperbus_ctrl.sv - HyperBus memory controller: CA phase, latency, burst write/read, recovery
// Optional read-wait timeout: define HYPERBUS_CTRL_TIMEOUT_EN.
module hyperbus_ctrl
    import hyperbus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 6,
    parameter int BURST_LEN  = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                  hbus_clk,
    input  logic                  hbus_rst_n,
    input  logic [ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic                  hbus_rrq,
    input  logic                  hbus_wrq,
    input  logic [DATA_WIDTH-1:0] hbus_dat_i,
    output logic [DATA_WIDTH-1:0] hbus_dat_o,
    output logic                  hbus_ready,
    output logic                  hbus_valid,
    output logic                  hbus_busy,
    output logic                  hbus_err,
    output logic                  cs_n,
    output logic                  ck_en,
    output logic [DATA_WIDTH-1:0] dq_o,
    output logic                  dq_oe,
    input  logic [DATA_WIDTH-1:0] dq_i,
    input  logic                  dq_i_valid,
    output logic [1:0]            rwds_o,
    output logic                  rwds_oe,
    input  logic                  rwds_i
);

    localparam int WCNT_W = $clog2(BURST_LEN + 1);
    localparam int LCNT_W = $clog2(2 * LATENCY + 1);
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(BURST_LEN - 1);
    localparam logic [LCNT_W-1:0] LAT_1X    = LCNT_W'(LATENCY);
    localparam logic [LCNT_W-1:0] LAT_2X    = LCNT_W'(2 * LATENCY);
    localparam logic [LCNT_W-1:0] LAT_ONE   = LCNT_W'(1);
    localparam logic [1:0]        REC_LAST  = 2'(RECOVER_CLKS - 1);

    state_t                state;
    pin_ctl_t              ctl;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic                  rd_q;
    logic [1:0]            phase_cnt;
    logic [LCNT_W-1:0]     lat_cnt;
    logic [WCNT_W-1:0]     word_cnt;
    logic [CA_W-1:0]       ca;

`ifdef HYPERBUS_CTRL_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TIMEOUT - 1);
    logic [TCNT_W-1:0] to_cnt;
    logic              err_q;

    assign hbus_err = err_q;
`else
    assign hbus_err = 1'b0;
`endif

    hyperbus_ca_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ca_gen (
        .adr(adr_q),
        .rd (rd_q),
        .ca (ca)
    );

    assign cs_n       = ctl.cs_n;
    assign ck_en      = ctl.ck_en;
    assign dq_oe      = ctl.dq_oe;
    assign rwds_oe    = ctl.rwds_oe;
    assign rwds_o     = ctl.rwds_o;
    assign hbus_ready = ctl.ready;
    assign hbus_busy  = ctl.busy;

    // DQ word: CA words in order during CMD, write data passes straight through in WRITE
    always_comb begin
        dq_o = '0;
        if (state == ST_CMD) begin
            case (phase_cnt)
                2'd0:    dq_o = DATA_WIDTH'(ca[47:32]);
                2'd1:    dq_o = DATA_WIDTH'(ca[31:16]);
                default: dq_o = DATA_WIDTH'(ca[15:0]);
            endcase
        end else if (state == ST_WRITE) begin
            dq_o = hbus_dat_i;
        end
    end

    // Transaction sequencer; pin controls are registered together with each state change
    always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
        if (!hbus_rst_n) begin
            state      <= ST_IDLE;
            ctl        <= CTL_IDLE;
            adr_q      <= '0;
            rd_q       <= 1'b0;
            phase_cnt  <= '0;
            lat_cnt    <= '0;
            word_cnt   <= '0;
            hbus_valid <= 1'b0;
            hbus_dat_o <= '0;
`ifdef HYPERBUS_CTRL_TIMEOUT_EN
            to_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            hbus_valid <= 1'b0;
`ifdef HYPERBUS_CTRL_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (hbus_rrq || hbus_wrq) begin
                        adr_q     <= hbus_adr_i;
                        rd_q      <= hbus_rrq;
                        phase_cnt <= '0;
                        state     <= ST_CMD;
                        ctl       <= ctl_for(ST_CMD);
                    end
                end
                ST_CMD: begin
                    // Device signals doubled latency by holding RWDS high at the start of CA
                    if (phase_cnt == 2'd0) begin
                        lat_cnt <= rwds_i ? LAT_2X : LAT_1X;
                    end
                    if (phase_cnt == 2'd2) begin
                        phase_cnt <= '0;
                        state     <= ST_LAT;
                        ctl       <= ctl_for(ST_LAT);
                    end else begin
                        phase_cnt <= phase_cnt + 2'd1;
                    end
                end
                ST_LAT: begin
                    if (lat_cnt <= LAT_ONE) begin
                        lat_cnt  <= '0;
                        word_cnt <= '0;
                        state    <= rd_q ? ST_READ : ST_WRITE;
                        ctl      <= ctl_for(rd_q ? ST_READ : ST_WRITE);
                    end else begin
                        lat_cnt <= lat_cnt - LAT_ONE;
                    end
                end
                ST_WRITE: begin
                    if (word_cnt == WORD_LAST) begin
                        word_cnt  <= '0;
                        phase_cnt <= '0;
                        state     <= ST_RECOVER;
                        ctl       <= ctl_for(ST_RECOVER);
                    end else begin
                        word_cnt <= word_cnt + WCNT_W'(1);
                    end
                end
                ST_READ: begin
                    if (dq_i_valid) begin
                        hbus_dat_o <= dq_i;
                        hbus_valid <= 1'b1;
`ifdef HYPERBUS_CTRL_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                        if (word_cnt == WORD_LAST) begin
                            word_cnt  <= '0;
                            phase_cnt <= '0;
                            state     <= ST_RECOVER;
                            ctl       <= ctl_for(ST_RECOVER);
                        end else begin
                            word_cnt <= word_cnt + WCNT_W'(1);
                        end
                    end
`ifdef HYPERBUS_CTRL_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        to_cnt    <= '0;
                        err_q     <= 1'b1;
                        word_cnt  <= '0;
                        phase_cnt <= '0;
                        state     <= ST_RECOVER;
                        ctl       <= ctl_for(ST_RECOVER);
                    end else begin
                        to_cnt <= to_cnt + TCNT_W'(1);
                    end
`endif
                end
                ST_RECOVER: begin
                    if (phase_cnt == REC_LAST) begin
                        phase_cnt <= '0;
                        state     <= ST_IDLE;
                        ctl       <= ctl_for(ST_IDLE);
                    end else begin
                        phase_cnt <= phase_cnt + 2'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ctl   <= CTL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// tb/tb_hyperbus_ctrl.sv - scoreboard bench for hyperbus_ctrl (timeout scenario under HYPERBUS_CTRL_TIMEOUT_EN)
module tb_hyperbus_ctrl;

    logic        hbus_clk = 1'b0;
    logic        hbus_rst_n;
    logic [31:0] hbus_adr_i;
    logic        hbus_rrq;
    logic        hbus_wrq;
    logic [15:0] hbus_dat_i;
    logic [15:0] hbus_dat_o;
    logic        hbus_ready;
    logic        hbus_valid;
    logic        hbus_busy;
    logic        hbus_err;
    logic        cs_n;
    logic        ck_en;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic [15:0] dq_i;
    logic        dq_i_valid;
    logic [1:0]  rwds_o;
    logic        rwds_oe;
    logic        rwds_i;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic [15:0] stim_w[$];
    logic [15:0] stim_r[$];
    int          stim_r_exp;

    logic [47:0] m_ca;
    int m_cmd_n, m_first_ready, m_ready_n, m_valid_n, m_low_n, m_rec_n, m_err_n, m_err_c, m_end_c;

    hyperbus_ctrl dut (
        .hbus_clk  (hbus_clk),
        .hbus_rst_n(hbus_rst_n),
        .hbus_adr_i(hbus_adr_i),
        .hbus_rrq  (hbus_rrq),
        .hbus_wrq  (hbus_wrq),
        .hbus_dat_i(hbus_dat_i),
        .hbus_dat_o(hbus_dat_o),
        .hbus_ready(hbus_ready),
        .hbus_valid(hbus_valid),
        .hbus_busy (hbus_busy),
        .hbus_err  (hbus_err),
        .cs_n      (cs_n),
        .ck_en     (ck_en),
        .dq_o      (dq_o),
        .dq_oe     (dq_oe),
        .dq_i      (dq_i),
        .dq_i_valid(dq_i_valid),
        .rwds_o    (rwds_o),
        .rwds_oe   (rwds_oe),
        .rwds_i    (rwds_i)
    );

    always #5 hbus_clk = ~hbus_clk;

    // Drives one transaction cycle by cycle (c = 0 is the request cycle) and records what the pins did
    task automatic run_txn(input bit req_r, input bit req_w, input logic [31:0] adr, input bit rwds_lvl,
                           input int beat_c0, input int junk_c, input int wrq_c, input int max_c);
        int pushed_r;
        pushed_r = 0;
        m_ca = '0; m_cmd_n = 0; m_first_ready = -1; m_ready_n = 0; m_valid_n = 0;
        m_low_n = 0; m_rec_n = 0; m_err_n = 0; m_err_c = -1; m_end_c = -1;
        exp_q.delete();
        obs_q.delete();
        for (int c = 0; c < max_c; c++) begin
            @(negedge hbus_clk);
            hbus_rrq   = (c == 0) && req_r;
            hbus_wrq   = ((c == 0) && req_w) || (c == wrq_c);
            hbus_adr_i = adr;
            rwds_i     = rwds_lvl;
            if (hbus_ready && stim_w.size() > 0) begin
                hbus_dat_i = stim_w.pop_front();
                exp_q.push_back(hbus_dat_i);
            end
            dq_i_valid = 1'b0;
            dq_i       = 16'h0000;
            if (c == junk_c) begin
                dq_i_valid = 1'b1;
                dq_i       = 16'hDEAD;
            end else if (beat_c0 >= 0 && c >= beat_c0 && stim_r.size() > 0) begin
                dq_i_valid = 1'b1;
                dq_i       = stim_r.pop_front();
                if (pushed_r < stim_r_exp) begin
                    exp_q.push_back(dq_i);
                    pushed_r++;
                end
            end
            #1;
            if (!cs_n && dq_oe && !rwds_oe) begin
                m_ca = {m_ca[31:0], dq_o};
                m_cmd_n++;
            end
            if (hbus_ready) begin
                obs_q.push_back(dq_o);
                m_ready_n++;
                if (m_first_ready < 0) m_first_ready = c;
            end
            if (hbus_valid) begin
                obs_q.push_back(hbus_dat_o);
                m_valid_n++;
            end
            if (hbus_err) begin
                m_err_n++;
                if (m_err_c < 0) m_err_c = c;
            end
            if (!cs_n) m_low_n++;
            if (c > 0 && cs_n && hbus_busy) m_rec_n++;
            if (c > 0 && !hbus_busy) begin
                m_end_c = c;
                break;
            end
        end
        hbus_rrq   = 1'b0;
        hbus_wrq   = 1'b0;
        dq_i_valid = 1'b0;
    endtask

    task automatic test_reset();
        hbus_rst_n = 1'b0;
        repeat (2) @(negedge hbus_clk);
        n_total++; if (cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b expected 1", cs_n); else n_pass++;
        n_total++; if (ck_en !== 1'b0) $display("FAIL rst_ck_en: got %b expected 0", ck_en); else n_pass++;
        n_total++; if ({dq_oe, rwds_oe, rwds_o} !== 4'b0011) $display("FAIL rst_oe_mask: got %b expected 0011", {dq_oe, rwds_oe, rwds_o}); else n_pass++;
        n_total++; if ({hbus_ready, hbus_valid, hbus_busy, hbus_err} !== 4'b0000) $display("FAIL rst_status: got %b expected 0000", {hbus_ready, hbus_valid, hbus_busy, hbus_err}); else n_pass++;
        n_total++; if ({dq_o, hbus_dat_o} !== 32'h0) $display("FAIL rst_data: got %h expected 00000000", {dq_o, hbus_dat_o}); else n_pass++;
        hbus_rst_n = 1'b1;
        @(negedge hbus_clk);
    endtask

    task automatic test_write();
        logic [15:0] e, o;
        stim_w = '{16'hAAAA, 16'h5555};
        run_txn(1'b0, 1'b1, 32'h0000_1234, 1'b0, -1, -1, -1, 60);
        n_total++; if (m_ca !== 48'h2000_0246_0004) $display("FAIL wr_ca: got %h expected 200002460004", m_ca); else n_pass++;
        n_total++; if (m_cmd_n != 3) $display("FAIL wr_cmd_clks: got %0d expected 3", m_cmd_n); else n_pass++;
        n_total++; if (m_first_ready != 10) $display("FAIL wr_latency: first ready at %0d expected 10", m_first_ready); else n_pass++;
        n_total++; if (m_ready_n != 2) $display("FAIL wr_ready_clks: got %0d expected 2", m_ready_n); else n_pass++;
        n_total++; if (m_low_n != 11) $display("FAIL wr_cs_low: got %0d expected 11", m_low_n); else n_pass++;
        n_total++; if (m_rec_n != 2) $display("FAIL wr_recover: got %0d expected 2", m_rec_n); else n_pass++;
        n_total++; if (m_end_c != 14) $display("FAIL wr_idle_at: got %0d expected 14", m_end_c); else n_pass++;
        n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL wr_word_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL wr_dq_o: got %h expected %h", o, e); else n_pass++;
        end
    endtask

    task automatic test_read();
        logic [15:0] e, o;
        stim_r     = '{16'hBEEF, 16'hCAFE, 16'h7777};
        stim_r_exp = 2;
        run_txn(1'b1, 1'b0, 32'h0000_0010, 1'b1, 16, 15, -1, 60);
        n_total++; if (m_ca !== 48'hA000_0002_0000) $display("FAIL rd_ca: got %h expected a00000020000", m_ca); else n_pass++;
        n_total++; if (m_valid_n != 2) $display("FAIL rd_valid_count: got %0d expected 2", m_valid_n); else n_pass++;
        n_total++; if (m_ready_n != 0) $display("FAIL rd_no_ready: got %0d expected 0", m_ready_n); else n_pass++;
        n_total++; if (m_low_n != 17) $display("FAIL rd_cs_low: got %0d expected 17", m_low_n); else n_pass++;
        n_total++; if (m_rec_n != 2) $display("FAIL rd_recover: got %0d expected 2", m_rec_n); else n_pass++;
        n_total++; if (m_end_c != 20) $display("FAIL rd_busy_fall: got %0d expected 20", m_end_c); else n_pass++;
        n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL rd_word_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL rd_dat_o: got %h expected %h", o, e); else n_pass++;
        end
        stim_r.delete();
    endtask

    task automatic test_both_req();
        logic [15:0] e, o;
        stim_r     = '{16'h0102, 16'h0304};
        stim_r_exp = 2;
        run_txn(1'b1, 1'b1, 32'h0000_0008, 1'b0, 10, 9, -1, 60);
        n_total++; if (m_ca[47] !== 1'b1) $display("FAIL both_rw_bit: got %b expected 1", m_ca[47]); else n_pass++;
        n_total++; if (m_ca !== 48'hA000_0001_0000) $display("FAIL both_ca: got %h expected a00000010000", m_ca); else n_pass++;
        n_total++; if (m_valid_n != 2) $display("FAIL both_valid_count: got %0d expected 2", m_valid_n); else n_pass++;
        n_total++; if (m_end_c != 14) $display("FAIL both_idle_at: got %0d expected 14", m_end_c); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL both_dat_o: got %h expected %h", o, e); else n_pass++;
        end
        stim_r.delete();
    endtask

    task automatic test_wrq_in_lat();
        int extra_low;
        stim_w = '{16'h0F0F, 16'hF0F0};
        run_txn(1'b0, 1'b1, 32'h0000_0040, 1'b0, -1, -1, 5, 60);
        n_total++; if (m_ready_n != 2) $display("FAIL lat_wrq_ready: got %0d expected 2", m_ready_n); else n_pass++;
        n_total++; if (m_low_n != 11) $display("FAIL lat_wrq_cs_low: got %0d expected 11", m_low_n); else n_pass++;
        n_total++; if (m_end_c != 14) $display("FAIL lat_wrq_idle_at: got %0d expected 14", m_end_c); else n_pass++;
        extra_low = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge hbus_clk);
            if (!cs_n || hbus_busy) extra_low++;
        end
        n_total++; if (extra_low != 0) $display("FAIL lat_wrq_second_txn: active clocks %0d expected 0", extra_low); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge hbus_clk);
            hbus_wrq   = (c == 0);
            hbus_adr_i = 32'h0000_0100;
            rwds_i     = 1'b0;
            hbus_dat_i = 16'h1111;
            #1;
            if (hbus_ready) begin
                seen = 1'b1;
                break;
            end
        end
        hbus_wrq = 1'b0;
        n_total++; if (!seen) $display("FAIL mid_rst_reach_write: got no ready expected ready within 40 clocks"); else n_pass++;
        hbus_rst_n = 1'b0;
        #1;
        n_total++; if ({cs_n, dq_oe} !== 2'b10) $display("FAIL mid_rst_async_pins: got cs_n,dq_oe=%b expected 10", {cs_n, dq_oe}); else n_pass++;
        n_total++; if ({hbus_busy, hbus_ready, rwds_oe} !== 3'b000) $display("FAIL mid_rst_async_status: got %b expected 000", {hbus_busy, hbus_ready, rwds_oe}); else n_pass++;
        n_total++; if (dq_o !== 16'h0000) $display("FAIL mid_rst_dq_o: got %h expected 0000", dq_o); else n_pass++;
        @(negedge hbus_clk);
        hbus_rst_n = 1'b1;
        repeat (3) @(negedge hbus_clk);
        n_total++; if ({cs_n, hbus_busy} !== 2'b10) $display("FAIL mid_rst_idle: got cs_n,busy=%b expected 10", {cs_n, hbus_busy}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e, o;
        stim_w = '{16'h0001, 16'hFFFF};
        run_txn(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, -1, -1, -1, 60);
        n_total++; if (m_ca !== 48'h3FFF_FFFF_0007) $display("FAIL b2b_ca0: got %h expected 3fffffff0007", m_ca); else n_pass++;
        n_total++; if (m_end_c != 14) $display("FAIL b2b_idle0: got %0d expected 14", m_end_c); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL b2b_dq_o0: got %h expected %h", o, e); else n_pass++;
        end
        stim_w = '{16'h1234, 16'h8000};
        run_txn(1'b0, 1'b1, 32'h0000_0000, 1'b0, -1, -1, -1, 60);
        n_total++; if (m_ca !== 48'h2000_0000_0000) $display("FAIL b2b_ca1: got %h expected 200000000000", m_ca); else n_pass++;
        n_total++; if (m_ready_n != 2) $display("FAIL b2b_ready1: got %0d expected 2", m_ready_n); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL b2b_dq_o1: got %h expected %h", o, e); else n_pass++;
        end
    endtask

`ifdef HYPERBUS_CTRL_TIMEOUT_EN
    task automatic test_read_timeout();
        stim_r.delete();
        stim_r_exp = 0;
        run_txn(1'b1, 1'b0, 32'h0000_0020, 1'b0, -1, -1, -1, 400);
        n_total++; if (m_err_n != 1) $display("FAIL to_err_count: got %0d expected 1", m_err_n); else n_pass++;
        n_total++; if (m_err_c != 265) $display("FAIL to_err_at: got %0d expected 265", m_err_c); else n_pass++;
        n_total++; if (m_low_n != 264) $display("FAIL to_cs_low: got %0d expected 264", m_low_n); else n_pass++;
        n_total++; if (m_rec_n != 2) $display("FAIL to_recover: got %0d expected 2", m_rec_n); else n_pass++;
        n_total++; if (m_end_c != 267) $display("FAIL to_idle_at: got %0d expected 267", m_end_c); else n_pass++;
        n_total++; if (m_valid_n != 0) $display("FAIL to_no_valid: got %0d expected 0", m_valid_n); else n_pass++;
    endtask
`else
    task automatic test_read_timeout();
        stim_r.delete();
        stim_r_exp = 0;
        run_txn(1'b1, 1'b0, 32'h0000_0020, 1'b0, -1, -1, -1, 300);
        n_total++; if (m_err_n != 0) $display("FAIL wait_err_tied: got %0d pulses expected 0", m_err_n); else n_pass++;
        n_total++; if (m_end_c != -1) $display("FAIL wait_still_busy: idle at %0d expected still busy", m_end_c); else n_pass++;
        n_total++; if (m_low_n != 299) $display("FAIL wait_cs_low: got %0d expected 299", m_low_n); else n_pass++;
        hbus_rst_n = 1'b0;
        @(negedge hbus_clk);
        hbus_rst_n = 1'b1;
        @(negedge hbus_clk);
        n_total++; if (hbus_busy !== 1'b0) $display("FAIL wait_reset_exit: got busy %b expected 0", hbus_busy); else n_pass++;
    endtask
`endif

    initial begin
        hbus_rst_n = 1'b0;
        hbus_adr_i = '0;
        hbus_rrq   = 1'b0;
        hbus_wrq   = 1'b0;
        hbus_dat_i = '0;
        dq_i       = '0;
        dq_i_valid = 1'b0;
        rwds_i     = 1'b0;
        stim_r_exp = 0;
        test_reset();
        test_write();
        test_read();
        test_both_req();
        test_wrq_in_lat();
        test_reset_mid_write();
        test_back_to_back();
        test_read_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
